// File: rtl/noc_config_injector_if.sv
// Request channel from the processor plus the configure/ack pair towards the mesh.
interface noc_config_injector_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_dest;
    logic [7:0]  req_payload;
    logic [10:0] configure;
    logic        processor_ready;

    modport master (
        output req_valid, req_dest, req_payload, processor_ready,
        input  req_ready, configure
    );

    modport slave (
        input  req_valid, req_dest, req_payload, processor_ready,
        output req_ready, configure
    );
endinterface

// File: rtl/noc_config_injector.sv
// Queues processor requests and drives them one at a time onto the mesh configure word.
// Optional macro NOC_INJ_RETRY_EN: a timed-out request is re-driven once before being discarded.
module noc_config_injector #(
    parameter int NODE_ID = 0,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int GAP     = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    noc_config_injector_if.slave   bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             sent_count,
    output logic                   timeout_err,
    output logic                   drop_self
);
    localparam int         AW       = $clog2(DEPTH);
    localparam int         CW       = AW + 1;
    localparam logic [1:0] NODE_L   = 2'(NODE_ID);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [9:0]    mem_q [DEPTH];
    logic [9:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    wait_q, wait_d;
    logic [3:0]    gap_q, gap_d;
    logic [10:0]   cfg_q, cfg_d;
    logic [7:0]    sent_q, sent_d;
    logic          tmo_q, tmo_d;
    logic          drop_q, drop_d;
`ifdef NOC_INJ_RETRY_EN
    logic          retry_pend_q, retry_pend_d;
    logic          retry_used_q, retry_used_d;
    logic [9:0]    retry_item_q, retry_item_d;
`endif

    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic [9:0]    head_s;

    // FIFO entries are stored as {dest, payload}
    assign ready_s = (count_q != CW'(DEPTH));
    assign push_s  = bus.req_valid & ready_s;
    assign head_s  = mem_q[rd_ptr_q];

    // FIFO storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {bus.req_dest, bus.req_payload};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Injector FSM: next state, configure word and status pulses
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        cfg_d   = cfg_q;
        sent_d  = sent_q;
        tmo_d   = 1'b0;
        drop_d  = 1'b0;
        pop_s   = 1'b0;
`ifdef NOC_INJ_RETRY_EN
        retry_pend_d = retry_pend_q;
        retry_used_d = retry_used_q;
        retry_item_d = retry_item_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cfg_d = 11'd0;
`ifdef NOC_INJ_RETRY_EN
                // A pending retry takes precedence over fresh FIFO entries
                if (retry_pend_q) begin
                    cfg_d        = {retry_item_q[7:0], retry_item_q[9:8], 1'b1};
                    retry_pend_d = 1'b0;
                    retry_used_d = 1'b1;
                    wait_d       = 8'd0;
                    state_d      = ST_DRIVE;
                end else
`endif
                if (count_q != CW'(0)) begin
                    pop_s = 1'b1;
                    if (head_s[9:8] == NODE_L) begin
                        drop_d = 1'b1;
                    end else begin
                        cfg_d   = {head_s[7:0], head_s[9:8], 1'b1};
                        wait_d  = 8'd0;
                        state_d = ST_DRIVE;
`ifdef NOC_INJ_RETRY_EN
                        retry_used_d = 1'b0;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (bus.processor_ready) begin
                    cfg_d   = 11'd0;
                    sent_d  = sent_q + 8'd1;
                    gap_d   = 4'd0;
                    state_d = ST_GAP;
                end else if (wait_q == TMO_LAST) begin
                    cfg_d   = 11'd0;
                    tmo_d   = 1'b1;
                    gap_d   = 4'd0;
                    state_d = ST_GAP;
`ifdef NOC_INJ_RETRY_EN
                    if (!retry_used_q) begin
                        retry_pend_d = 1'b1;
                        retry_item_d = {cfg_q[2:1], cfg_q[10:3]};
                    end else begin
                        retry_pend_d = 1'b0;
                    end
`endif
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_GAP: begin
                cfg_d = 11'd0;
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cfg_d   = 11'd0;
            end
        endcase
    end

    // State registers; reset discards any in-flight and queued request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= 8'd0;
            gap_q    <= 4'd0;
            cfg_q    <= 11'd0;
            sent_q   <= 8'd0;
            tmo_q    <= 1'b0;
            drop_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 10'd0;
            end
`ifdef NOC_INJ_RETRY_EN
            retry_pend_q <= 1'b0;
            retry_used_q <= 1'b0;
            retry_item_q <= 10'd0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            gap_q    <= gap_d;
            cfg_q    <= cfg_d;
            sent_q   <= sent_d;
            tmo_q    <= tmo_d;
            drop_q   <= drop_d;
            mem_q    <= mem_d;
`ifdef NOC_INJ_RETRY_EN
            retry_pend_q <= retry_pend_d;
            retry_used_q <= retry_used_d;
            retry_item_q <= retry_item_d;
`endif
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.configure = cfg_q;
    assign fifo_count    = count_q;
    assign sent_count    = sent_q;
    assign timeout_err   = tmo_q;
    assign drop_self     = drop_q;
`ifdef NOC_INJ_RETRY_EN
    assign busy = (state_q != ST_IDLE) || (count_q != CW'(0)) || retry_pend_q;
`else
    assign busy = (state_q != ST_IDLE) || (count_q != CW'(0));
`endif

endmodule

// File: tb/tb_noc_config_injector.sv
// Randomised and directed bench for noc_config_injector against a queue-based transaction model.
module tb_noc_config_injector;
    localparam int NODE_ID = 0;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int GAP     = 2;
`ifdef NOC_INJ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [7:0]             sent_count;
    logic                   timeout_err;
    logic                   drop_self;

    int n_checks = 0;
    int n_errors = 0;
    int obs_tmo  = 0;
    int obs_drop = 0;

    noc_config_injector_if bus ();

    noc_config_injector #(
        .NODE_ID(NODE_ID), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP(GAP)
    ) dut (
        .clock      (clk),
        .reset      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .fifo_count (fifo_count),
        .sent_count (sent_count),
        .timeout_err(timeout_err),
        .drop_self  (drop_self)
    );

    always #5 clk = ~clk;

    // Reference model: pending requests, the one being driven, and time left in the gap
    logic [9:0] m_q[$];
    bit         m_drv;
    logic [9:0] m_item;
    int         m_age;
    bit         m_used;
    int         m_gap;
    bit         m_retry;
    logic [9:0] m_retry_item;
    int         m_sent_total;
    bit         m_tmo;
    bit         m_drop;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_drv = 1'b0; m_item = 10'd0; m_age = 0; m_used = 1'b0;
        m_gap = 0; m_retry = 1'b0; m_retry_item = 10'd0;
        m_sent_total = 0; m_tmo = 1'b0; m_drop = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [1:0] d, input logic [7:0] p, input bit pr);
        bit accept;
        logic [9:0] head;
        accept = v && (m_q.size() < DEPTH);
        m_tmo  = 1'b0;
        m_drop = 1'b0;
        if (m_drv) begin
            if (pr) begin
                m_sent_total++;
                m_drv = 1'b0;
                m_gap = GAP;
            end else if (m_age + 1 >= TIMEOUT) begin
                m_tmo = 1'b1;
                m_drv = 1'b0;
                m_gap = GAP;
                if (RETRY && !m_used) begin
                    m_retry      = 1'b1;
                    m_retry_item = m_item;
                end
            end else begin
                m_age++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (m_retry) begin
            m_retry = 1'b0; m_drv = 1'b1; m_item = m_retry_item; m_age = 0; m_used = 1'b1;
        end else if (m_q.size() > 0) begin
            head = m_q.pop_front();
            if (head[9:8] == 2'(NODE_ID)) begin
                m_drop = 1'b1;
            end else begin
                m_drv = 1'b1; m_item = head; m_age = 0; m_used = 1'b0;
            end
        end
        if (accept) m_q.push_back({d, p});
    endtask

    function automatic logic [10:0] exp_cfg();
        return m_drv ? {m_item[7:0], m_item[9:8], 1'b1} : 11'd0;
    endfunction

    task automatic check_all();
        if (timeout_err) obs_tmo++;
        if (drop_self) obs_drop++;
        check_eq("configure",   bus.configure, exp_cfg());
        check_eq("req_ready",   bus.req_ready, m_q.size() < DEPTH);
        check_eq("fifo_count",  fifo_count, m_q.size());
        check_eq("fifo_bound",  fifo_count <= DEPTH, 1);
        check_eq("busy",        busy, m_drv || (m_gap > 0) || (m_q.size() > 0) || m_retry);
        check_eq("sent_count",  sent_count, m_sent_total % 256);
        check_eq("timeout_err", timeout_err, m_tmo);
        check_eq("drop_self",   drop_self, m_drop);
    endtask

    task automatic step(input bit v, input logic [1:0] d, input logic [7:0] p, input bit pr);
        bus.req_valid       = v;
        bus.req_dest        = d;
        bus.req_payload     = p;
        bus.processor_ready = pr;
        @(posedge clk);
        model_edge(v, d, p, pr);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'd0, 1'b0);
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0; bus.processor_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        bus.req_valid = 1'b0; bus.req_dest = 2'd0; bus.req_payload = 8'd0; bus.processor_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Single transfer acknowledged after three drive cycles
        step(1'b1, 2'd1, 8'd1, 1'b0);
        step(1'b0, 2'd0, 8'd0, 1'b0);
        check_eq("first_cfg", bus.configure, 11'b00000001011);
        step(1'b0, 2'd0, 8'd0, 1'b0);
        step(1'b0, 2'd0, 8'd0, 1'b0);
        step(1'b0, 2'd0, 8'd0, 1'b1);
        idle(4);
        check_eq("first_sent", sent_count, 8'd1);

        // Request addressed to this node is discarded
        obs_drop = 0;
        step(1'b1, 2'd0, 8'h55, 1'b0);
        idle(4);
        check_eq("drop_pulses", obs_drop, 1);
        check_eq("drop_sent", sent_count, 8'd1);

        // Drive abandoned after TIMEOUT cycles, retried once when enabled
        obs_tmo = 0;
        step(1'b1, 2'd2, 8'h33, 1'b0);
        idle(40);
        check_eq("tmo_pulses", obs_tmo, RETRY ? 2 : 1);

        // Acknowledge in the last allowed cycle beats the timeout
        obs_tmo = 0;
        step(1'b1, 2'd3, 8'hC3, 1'b0);
        step(1'b0, 2'd0, 8'd0, 1'b0);
        idle(TIMEOUT - 1);
        step(1'b0, 2'd0, 8'd0, 1'b1);
        check_eq("ack_wins_tmo", obs_tmo, 0);
        check_eq("ack_wins_sent", sent_count, 8'd2);
        idle(4);

        // Back-to-back pushes against a stalled mesh fill the FIFO
        for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 8'($urandom), 1'b0);
        check_eq("fill_count", fifo_count, DEPTH);
        check_eq("fill_ready", bus.req_ready, 1'b0);
        step(1'b1, 2'd1, 8'hEE, 1'b0);
        check_eq("fill_refused", fifo_count, DEPTH);
        idle(200);

        // Reset in the middle of a drive with three requests queued
        for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 8'($urandom), 1'b0);
        check_eq("pre_rst_count", fifo_count, 3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_cfg",   bus.configure, 11'd0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_busy",  busy, 1'b0);
        check_eq("rst_ready", bus.req_ready, 1'b1);
        model_reset();
        obs_tmo = 0; obs_drop = 0;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        idle(3);
        check_eq("rst_no_pulse", obs_tmo + obs_drop, 0);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom), 2'($urandom), 8'($urandom), $urandom_range(0, 2) == 0);
        end
        idle(60);

        // 256 acknowledged transfers wrap sent_count
        do_reset();
        cyc = 0;
        while (m_sent_total < 256 && cyc < 4000) begin
            step(1'b1, 2'($urandom_range(1, 3)), 8'($urandom), 1'b1);
            cyc++;
        end
        check_eq("wrap_budget", m_sent_total, 256);
        check_eq("wrap_sent", sent_count, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
